ins_prefetch_queue: RTL and testbench
=====================================

// Module: ins_prefetch_queue
// PURPOSE
//  Instruction fetch front end: sits between instruction memory and the ID-stage decoder.
//  Issues sequential fetches over a req/ack memory handshake and buffers {pc, instruction} pairs in a small FIFO.
//  Presents the FIFO head to ID with a valid/stall handshake.
//  A redirect from jump control flushes the buffer and restarts fetching at a new PC.
// PARAMETERS
//  DEPTH        4              FIFO entries (power of two, >=2)
//  RESET_PC     32'h0000_0000  first fetch address after reset; also the wrap target
//  MAX_INSADDR  32'hffff_fff8  highest legal fetch address; the sequential PC wraps past it
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  redirect     in   1   flush queue and refetch from redirect_pc (jump/clr from ID)
//  redirect_pc  in   32  new fetch address; bits [1:0] forced to 0
//  id_stall     in   1   ID cannot accept this cycle (hazard stall)
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  fetch address; held stable while imem_req=1
//  imem_ack     in   1   memory returns imem_data this cycle (same-cycle ack legal)
//  imem_data    in   32  fetched instruction word
//  ins_valid    out  1   ins/ins_pc hold a valid instruction
//  ins          out  32  head instruction to the decoder; 32'h0 (NOP) when !ins_valid
//  ins_pc       out  32  PC of ins; 32'h0 when !ins_valid
// BEHAVIOUR
//  - Reset values: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0, count=0, state=RUN.
//  - A reset mid-request abandons the outstanding fetch without waiting for its ack.
//  - At most one outstanding fetch.
//  - Issue rule: imem_req rises when state=RUN and count + inflight < DEPTH.
//    The first request goes out the first cycle after rst deasserts.
//  - Handshake: once imem_req=1, imem_req and imem_addr stay unchanged until the imem_ack cycle.
//  - On ack in RUN: push {imem_addr, imem_data}.
//    Next fetch address = imem_addr+4; if imem_addr+4 > MAX_INSADDR, the next address is RESET_PC.
//    A back-to-back request in the cycle after the ack is allowed if there is room.
//  - Pop: when ins_valid=1 and id_stall=0, the head advances at the clock edge.
//  - Push and pop in the same cycle leave count unchanged. Full: no request is issued.
//    Overflow is impossible by the issue rule.
//  - Empty: ins_valid=0.
//  - Latency: ack in cycle N -> entry visible on ins/ins_valid in cycle N+1 (when the queue was empty).
//  - Redirect (highest priority, beats push and pop):
//    - count<=0 and fetch PC<=redirect_pc & ~3.
//    - ins_valid=0 in the cycle after redirect.
//  - FSM RUN/DISCARD:
//    - RUN -> DISCARD: redirect with a request outstanding and no imem_ack that cycle.
//    - In DISCARD: keep imem_req asserted on the old address; drop data at the ack; no pushes.
//    - DISCARD -> RUN: on the ack; the request for the redirect PC issues the next cycle.
//    - A redirect during DISCARD only updates the stored redirect PC.
//    - Redirect coincident with ack: data dropped, stay RUN, request the redirect PC next cycle.
//  - Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
//    count is log2(DEPTH)+1 bits wide.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//    - When the queue is empty, in RUN, with no redirect, imem_ack=1 makes {imem_addr, imem_data} appear
//      combinationally on ins/ins_pc with ins_valid=1 in the same cycle (0-cycle latency).
//    - If id_stall=0, the word is consumed and not pushed; otherwise it is pushed as normal.
//  IFQ_BYPASS_EN undefined: outputs come only from FIFO registers; fixed 1-cycle ack-to-valid latency.
// TESTING
//  1. Reset release, imem acks every cycle, id_stall=0
//     -> imem_addr 0,4,8,...; ins_pc follows 0,4,8 one cycle behind the acks.
//  2. id_stall=1 held for 10 cycles, DEPTH=4 -> exactly 4 pushes, then imem_req=0.
//     Release -> 4 pops in order, then fetching resumes at 0x10.
//  3. Redirect to 0x103 while a fetch of 0x8 is unacked and acks are delayed 3 cycles
//     -> req held on 0x8, its data dropped, next request at 0x100, first ins_pc=0x100.
//  4. RESET_PC=0, MAX_INSADDR=0x8, continuous acks -> addresses 0,4,8,0,4.
//  5. Assert rst low mid-request with 2 entries queued
//     -> ins_valid=0 and imem_req=0 immediately (async); first request at 0x0 after release.
//  6. IFQ_BYPASS_EN, empty queue, ack of 0x2002_0005 at 0x0 -> ins=0x2002_0005, ins_valid=1 in the same cycle.
//     Without the macro -> visible one cycle later.

Source files
------------

// File: rtl/ins_prefetch_queue_if.sv
// Handshake bundle for the instruction prefetch queue: redirect control,
// instruction-memory req/ack bus and the decoder-facing valid/stall port.
interface ins_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;

  modport master (
    input  redirect, redirect_pc, id_stall, imem_ack, imem_data,
    output imem_req, imem_addr, ins_valid, ins, ins_pc
  );

  modport slave (
    output redirect, redirect_pc, id_stall, imem_ack, imem_data,
    input  imem_req, imem_addr, ins_valid, ins, ins_pc
  );
endinterface

// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch queue: sequential fetcher with a small {pc, ins} FIFO and redirect flush.
// Optional IFQ_BYPASS_EN presents an ack'd word to the decoder in the same cycle when the queue is empty.
module ins_prefetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8
) (
  input  logic                 clk,
  input  logic                 rst,
  ins_prefetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RUN, DISCARD} state_t;

  state_t        state;
  logic          req;
  logic [31:0]   addr;
  logic [31:0]   pend_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic          ack;
  logic          fifo_valid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [32:0]   addr_inc;
  logic [31:0]   seq_pc;
  logic [31:0]   redir_aligned;

  assign ack           = req && bus.imem_ack;
  assign fifo_valid    = (count != '0);
  assign redir_aligned = bus.redirect_pc & ~32'h3;
  assign addr_inc      = {1'b0, addr} + 33'd4;
  assign seq_pc        = (addr_inc > {1'b0, MAX_INSADDR}) ? RESET_PC : addr_inc[31:0];

`ifdef IFQ_BYPASS_EN
  assign bypass = (state == RUN) && !fifo_valid && !bus.redirect && ack;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by the decoder this cycle never enters the FIFO.
  assign push = (state == RUN) && ack && !bus.redirect && !(bypass && !bus.id_stall);
  assign pop  = fifo_valid && !bus.id_stall && !bus.redirect;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= addr;
      ins_mem[wr_ptr] <= bus.imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      req     <= 1'b0;
      addr    <= RESET_PC;
      pend_pc <= RESET_PC;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (bus.redirect) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pend_pc <= redir_aligned;
      if (state == DISCARD) begin
        if (ack) begin
          state <= RUN;
          addr  <= redir_aligned;
          req   <= 1'b1;
        end
      end else if (req && !ack) begin
        // Outstanding fetch must complete on the old address before refetching.
        state <= DISCARD;
      end else begin
        addr <= redir_aligned;
        req  <= 1'b1;
      end
    end else begin
      count <= count_next;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (state == DISCARD) begin
        if (ack) begin
          state <= RUN;
          addr  <= pend_pc;
          req   <= 1'b1;
        end
      end else begin
        if (ack)
          addr <= seq_pc;
        // Room is judged after this cycle's push/pop so count + inflight never exceeds DEPTH.
        if (!req || ack)
          req <= (count_next < CW'(DEPTH));
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.ins_valid = fifo_valid || bypass;
  assign bus.ins       = fifo_valid ? ins_mem[rd_ptr] : (bypass ? bus.imem_data : 32'h0);
  assign bus.ins_pc    = fifo_valid ? pc_mem[rd_ptr]  : (bypass ? addr          : 32'h0);
endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Self-checking bench for ins_prefetch_queue: directed scenarios plus a randomized run
// checked against a stream-level model of the PCs the decoder should consume.
module tb_ins_prefetch_queue;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] MAXA = 32'hffff_fff8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   force_data = 1'b0;
  logic [31:0] forced_word = 32'h0;

  always #5 clk = ~clk;

  ins_prefetch_queue_if bus ();
  ins_prefetch_queue_if bus2 ();

  ins_prefetch_queue #(.DEPTH(4), .RESET_PC(RPC0), .MAX_INSADDR(MAXA)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));

  ins_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .MAX_INSADDR(32'h8)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus2.master));

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    logic [32:0] s;
    s = {1'b0, p} + 33'd4;
    return (s > {1'b0, MAXA}) ? RPC0 : s[31:0];
  endfunction

  // One clock cycle: inputs applied 1ns after the edge, outputs sampled 2ns after it.
  task automatic step(input bit ack_en, input bit stall, input bit redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.id_stall    = stall;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_ack    = ack_en & bus.imem_req;
    bus.imem_data   = force_data ? forced_word : memf(bus.imem_addr);
    bus2.id_stall    = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'h0;
    bus2.imem_ack    = bus2.imem_req;
    bus2.imem_data   = memf(bus2.imem_addr);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_ack = 1'b0; bus.redirect = 1'b0; bus.id_stall = 1'b0;
    bus2.imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== RPC0) begin
      failures++;
      $display("FAIL reset_req: got req=%b addr=%h exp req=0 addr=%h", bus.imem_req, bus.imem_addr, RPC0);
    end
    checks++;
    if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0 || bus.ins_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_out: got valid=%b ins=%h pc=%h exp 0/0/0", bus.ins_valid, bus.ins, bus.ins_pc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_req: got %b exp 0", bus.imem_req);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC0) begin
      failures++;
      $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RPC0);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin
        failures++;
        $display("FAIL stream_addr[%0d]: got req=%b addr=%h exp req=1 addr=%h", k, bus.imem_req, bus.imem_addr, 32'(4 * k));
      end
`ifdef IFQ_BYPASS_EN
      checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'(4 * k) || bus.ins !== memf(32'(4 * k))) begin
        failures++;
        $display("FAIL stream_out[%0d]: got valid=%b pc=%h exp valid=1 pc=%h", k, bus.ins_valid, bus.ins_pc, 32'(4 * k));
      end
`else
      if (k == 0) begin
        checks++;
        if (bus.ins_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_out[0]: got valid=%b exp 0", bus.ins_valid);
        end
      end else begin
        checks++;
        if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'(4 * (k - 1)) || bus.ins !== memf(32'(4 * (k - 1)))) begin
          failures++;
          $display("FAIL stream_out[%0d]: got valid=%b pc=%h exp valid=1 pc=%h", k, bus.ins_valid, bus.ins_pc, 32'(4 * (k - 1)));
        end
      end
`endif
    end
  endtask

  task automatic test_stall_fill();
    int acks;
    acks = 0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (bus.imem_ack) acks++;
    end
    checks++;
    if (acks != 4 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL fill_count: got acks=%0d req=%b exp acks=4 req=0", acks, bus.imem_req);
    end
    checks++;
    if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0) begin
      failures++;
      $display("FAIL fill_head: got valid=%b pc=%h exp valid=1 pc=0", bus.ins_valid, bus.ins_pc);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'(4 * i) || bus.ins !== memf(32'(4 * i))) begin
        failures++;
        $display("FAIL drain[%0d]: got valid=%b pc=%h ins=%h exp valid=1 pc=%h ins=%h", i, bus.ins_valid, bus.ins_pc, bus.ins, 32'(4 * i), memf(32'(4 * i)));
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL resume: got req=%b addr=%h valid=%b exp req=1 addr=00000010 valid=0", bus.imem_req, bus.imem_addr, bus.ins_valid);
    end
  endtask

  task automatic test_redirect_discard();
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h103);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL redir_cycle: got req=%b addr=%h exp req=1 addr=00000008", bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.ins_valid !== 1'b0) begin
        failures++;
        $display("FAIL discard_hold[%0d]: got req=%b addr=%h valid=%b exp req=1 addr=00000008 valid=0", i, bus.imem_req, bus.imem_addr, bus.ins_valid);
      end
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_req: got req=%b addr=%h exp req=1 addr=00000100", bus.imem_req, bus.imem_addr);
    end
`ifndef IFQ_BYPASS_EN
    step(1'b0, 1'b0, 1'b0, 32'h0);
`endif
    checks++;
    if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h100 || bus.ins !== memf(32'h100)) begin
      failures++;
      $display("FAIL redir_first: got valid=%b pc=%h exp valid=1 pc=00000100", bus.ins_valid, bus.ins_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [5];
    int n;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4};
    n = 0;
    apply_reset();
    for (int c = 0; c < 20 && n < 5; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (bus2.imem_ack) begin
        checks++;
        if (bus2.imem_addr !== exp_addr[n]) begin
          failures++;
          $display("FAIL wrap_addr[%0d]: got %h exp %h", n, bus2.imem_addr, exp_addr[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL wrap_timeout: got %0d acks exp 5", n);
    end
  endtask

  task automatic test_reset_midreq();
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.ins_valid !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL midreq_setup: got valid=%b req=%b addr=%h exp 1/1/00000008", bus.ins_valid, bus.imem_req, bus.imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.ins !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b req=%b ins=%h exp 0/0/0", bus.ins_valid, bus.imem_req, bus.ins);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_req: got req=%b addr=%h valid=%b exp 1/00000000/0", bus.imem_req, bus.imem_addr, bus.ins_valid);
    end
  endtask

  task automatic test_latency();
    apply_reset();
    force_data  = 1'b1;
    forced_word = 32'h2002_0005;
    step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IFQ_BYPASS_EN
    checks++;
    if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h2002_0005 || bus.ins_pc !== 32'h0) begin
      failures++;
      $display("FAIL bypass_same: got valid=%b ins=%h pc=%h exp 1/20020005/00000000", bus.ins_valid, bus.ins, bus.ins_pc);
    end
`else
    checks++;
    if (bus.ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_same: got valid=%b exp 0", bus.ins_valid);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h2002_0005 || bus.ins_pc !== 32'h0) begin
      failures++;
      $display("FAIL latency_next: got valid=%b ins=%h pc=%h exp 1/20020005/00000000", bus.ins_valid, bus.ins, bus.ins_pc);
    end
`endif
    force_data = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] rpc;
    int consumed;
    bit pend, prev_redir, st, ak, rd;
    apply_reset();
    exp_pc = RPC0; consumed = 0; pend = 1'b0; prev_redir = 1'b0; pend_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 99) < 30);
      ak  = ($urandom_range(0, 99) < 50);
      rd  = ($urandom_range(0, 99) < 3);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hffff_ffe0 | ($urandom & 32'h1f)) : $urandom;
      step(ak, st, rd, rpc);
      if (pend) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== pend_addr) begin
          failures++;
          $display("FAIL rnd_hold[%0d]: got req=%b addr=%h exp req=1 addr=%h", c, bus.imem_req, bus.imem_addr, pend_addr);
        end
      end
      if (!bus.ins_valid) begin
        checks++;
        if (bus.ins !== 32'h0 || bus.ins_pc !== 32'h0) begin
          failures++;
          $display("FAIL rnd_nop[%0d]: got ins=%h pc=%h exp 0/0", c, bus.ins, bus.ins_pc);
        end
      end
`ifdef IFQ_BYPASS_EN
      if (prev_redir && !bus.imem_ack) begin
`else
      if (prev_redir) begin
`endif
        checks++;
        if (bus.ins_valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_flush[%0d]: got valid=%b exp 0", c, bus.ins_valid);
        end
      end
      if (bus.ins_valid && !st && !rd) begin
        checks++;
        if (bus.ins_pc !== exp_pc || bus.ins !== memf(exp_pc)) begin
          failures++;
          $display("FAIL rnd_stream[%0d]: got pc=%h ins=%h exp pc=%h ins=%h", c, bus.ins_pc, bus.ins, exp_pc, memf(exp_pc));
        end
        exp_pc = next_pc(exp_pc);
        consumed++;
      end
      if (rd) exp_pc = rpc & ~32'h3;
      pend       = bus.imem_req && !bus.imem_ack;
      pend_addr  = bus.imem_addr;
      prev_redir = rd;
    end
    checks++;
    if (consumed < 200) begin
      failures++;
      $display("FAIL rnd_progress: got %0d consumed exp >=200", consumed);
    end
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_stall = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
    bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0; bus2.id_stall = 1'b0;
    bus2.imem_ack = 1'b0; bus2.imem_data = 32'h0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_discard();
    test_wrap();
    test_reset_midreq();
    test_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
